// File: rtl/mdio_phy_ctrl_if.sv
// Command bus between the PHY control sequencer and the MDIO serial engine.
// One transaction is outstanding at a time: op_ena starts it, op_done ends it.
interface mdio_phy_ctrl_if;
  logic        op_ena;
  logic        op_rdwr;
  logic [4:0]  op_phya;
  logic [4:0]  op_rega;
  logic [15:0] op_din;
  logic [15:0] op_dout;
  logic        op_done;

  modport master (
    output op_ena, op_rdwr, op_phya, op_rega, op_din,
    input  op_dout, op_done
  );

  modport slave (
    input  op_ena, op_rdwr, op_phya, op_rega, op_din,
    output op_dout, op_done
  );
endinterface

// File: rtl/mdio_phy_ctrl.sv
// PHY bring-up, periodic BMSR polling and single-outstanding host register access,
// all sequenced onto one MDIO engine with a per-transaction timeout.
module mdio_phy_ctrl #(
  parameter logic [4:0]  PHY_ADDR  = 5'd0,
  parameter logic [15:0] ANAR_VAL  = 16'h01E1,
  parameter int unsigned POLL_DIV  = 32'd1_000_000,
  parameter int unsigned RST_POLLS = 16,
  parameter int unsigned TIMEOUT   = 32'd200_000
) (
  input  logic            clk,
  input  logic            rst_n,
  mdio_phy_ctrl_if.master op_if,
  input  logic            host_req_i,
  input  logic            host_rdwr_i,
  input  logic [4:0]      host_rega_i,
  input  logic [15:0]     host_din_i,
  output logic            host_ack_o,
  output logic [15:0]     host_dout_o,
  output logic            init_done_o,
  output logic            init_err_o,
  output logic            link_up_o,
  output logic            an_done_o,
  output logic            to_err_o
);

  typedef enum logic [2:0] {
    StRstWr, StRstRd, StAnarWr, StAnWr, StIdle, StHost, StPoll, StWait
  } state_e;

  state_e      state_q, ctx_q;
  logic        op_ena_q, op_rdwr_q;
  logic [4:0]  op_phya_q, op_rega_q;
  logic [15:0] op_din_q;
  logic        h_rdwr_q;
  logic [4:0]  h_rega_q;
  logic [15:0] h_din_q;
  logic        host_ack_q;
  logic [15:0] host_dout_q;
  logic        init_done_q, init_err_q, link_up_q, an_done_q, to_err_q;
  logic [31:0] to_cnt_q, poll_cnt_q;
  logic [4:0]  rst_cnt_q;

  logic        iss_rdwr;
  logic [4:0]  iss_rega;
  logic [15:0] iss_din;
  logic        done, tmo, poll_hit;
  logic [15:0] dout;

  assign done     = op_if.op_done;
  assign dout     = op_if.op_dout;
  assign tmo      = !op_if.op_done && (to_cnt_q == TIMEOUT - 1);
  assign poll_hit = (poll_cnt_q == POLL_DIV - 1);

  // Fields of the transaction launched from each issuing state.
  always_comb begin
    iss_rdwr = 1'b0;
    iss_rega = 5'd0;
    iss_din  = 16'h0000;
    case (state_q)
      StRstWr:  begin iss_rdwr = 1'b1; iss_din = 16'h8000; end
      StAnarWr: begin iss_rdwr = 1'b1; iss_rega = 5'd4; iss_din = ANAR_VAL; end
      StAnWr:   begin iss_rdwr = 1'b1; iss_din = 16'h1200; end
      StHost:   begin iss_rdwr = h_rdwr_q; iss_rega = h_rega_q; iss_din = h_din_q; end
      StPoll:   iss_rega = 5'd1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRstWr;
      ctx_q       <= StRstWr;
      op_ena_q    <= 1'b0;
      op_rdwr_q   <= 1'b0;
      op_phya_q   <= 5'd0;
      op_rega_q   <= 5'd0;
      op_din_q    <= 16'h0000;
      h_rdwr_q    <= 1'b0;
      h_rega_q    <= 5'd0;
      h_din_q     <= 16'h0000;
      host_ack_q  <= 1'b0;
      host_dout_q <= 16'h0000;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
      link_up_q   <= 1'b0;
      an_done_q   <= 1'b0;
      to_err_q    <= 1'b0;
      to_cnt_q    <= 32'd0;
      poll_cnt_q  <= 32'd0;
      rst_cnt_q   <= 5'd0;
    end else begin
      op_ena_q   <= 1'b0;
      host_ack_q <= 1'b0;
      op_phya_q  <= PHY_ADDR;
      case (state_q)
        StIdle: begin
          if (host_req_i) begin
            h_rdwr_q <= host_rdwr_i;
            h_rega_q <= host_rega_i;
            h_din_q  <= host_din_i;
            state_q  <= StHost;
            // A poll that expires together with a host request waits at its limit.
            if (!poll_hit) poll_cnt_q <= poll_cnt_q + 32'd1;
          end else if (poll_hit) begin
            poll_cnt_q <= 32'd0;
            state_q    <= StPoll;
          end else begin
            poll_cnt_q <= poll_cnt_q + 32'd1;
          end
        end
        StWait: begin
          if (done || tmo) begin
            state_q <= StIdle;
            if (tmo) begin
              to_err_q <= 1'b1;
              if (!(ctx_q inside {StHost, StPoll})) init_err_q <= 1'b1;
            end
            case (ctx_q)
              StRstWr:  if (!tmo) state_q <= StRstRd;
              StRstRd: begin
                if (!tmo) begin
                  if (!dout[15]) begin
                    state_q <= StAnarWr;
                  end else if (rst_cnt_q != 5'(RST_POLLS - 1)) begin
                    rst_cnt_q <= rst_cnt_q + 5'd1;
                    state_q   <= StRstRd;
                  end else begin
                    init_err_q <= 1'b1;
                  end
                end
              end
              StAnarWr: if (!tmo) state_q <= StAnWr;
              StAnWr:   if (!tmo) init_done_q <= 1'b1;
              StHost: begin
                host_ack_q <= 1'b1;
                if (tmo)            host_dout_q <= 16'hFFFF;
                else if (!h_rdwr_q) host_dout_q <= dout;
              end
              StPoll: begin
                if (tmo) begin
                  link_up_q <= 1'b0;
                end else begin
                  link_up_q <= dout[2];
                  an_done_q <= dout[5];
                end
              end
              default: ;
            endcase
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
        end
        default: begin
          op_ena_q  <= 1'b1;
          op_rdwr_q <= iss_rdwr;
          op_rega_q <= iss_rega;
          op_din_q  <= iss_din;
          ctx_q     <= state_q;
          to_cnt_q  <= 32'd0;
          state_q   <= StWait;
        end
      endcase
    end
  end

  assign op_if.op_ena  = op_ena_q;
  assign op_if.op_rdwr = op_rdwr_q;
  assign op_if.op_phya = op_phya_q;
  assign op_if.op_rega = op_rega_q;
  assign op_if.op_din  = op_din_q;
  assign host_ack_o    = host_ack_q;
  assign host_dout_o   = host_dout_q;
  assign init_done_o   = init_done_q;
  assign init_err_o    = init_err_q;
  assign link_up_o     = link_up_q;
  assign an_done_o     = an_done_q;
  assign to_err_o      = to_err_q;

endmodule

// File: tb/tb_mdio_phy_ctrl.sv
// Bench for mdio_phy_ctrl: MDIO engine/PHY model, vector tables, corner sequences
// and randomized host traffic checked against a simple register-file reference.
module tb_mdio_phy_ctrl;
  localparam logic [4:0]  PhyA     = 5'd3;
  localparam logic [15:0] Anar     = 16'h01E1;
  localparam int          PollDiv  = 100;
  localparam int          RstPolls = 4;
  localparam int          Tmo      = 50;

  typedef struct {
    logic        rdwr;
    logic [4:0]  rega;
    logic [15:0] din;
    int          cyc;
    int          gap;
  } txn_t;

  typedef struct {
    logic        rw;
    logic [4:0]  a;
    logic [15:0] d;
    logic [15:0] exp;
  } hvec_t;

  logic        clk, rst_n;
  logic        host_req, host_rdwr;
  logic [4:0]  host_rega;
  logic [15:0] host_din;
  logic        host_ack;
  logic [15:0] host_dout;
  logic        init_done, init_err, link_up, an_done, to_err;

  mdio_phy_ctrl_if bus ();

  mdio_phy_ctrl #(
    .PHY_ADDR (PhyA),
    .ANAR_VAL (Anar),
    .POLL_DIV (PollDiv),
    .RST_POLLS(RstPolls),
    .TIMEOUT  (Tmo)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_if      (bus),
    .host_req_i (host_req),
    .host_rdwr_i(host_rdwr),
    .host_rega_i(host_rega),
    .host_din_i (host_din),
    .host_ack_o (host_ack),
    .host_dout_o(host_dout),
    .init_done_o(init_done),
    .init_err_o (init_err),
    .link_up_o  (link_up),
    .an_done_o  (an_done),
    .to_err_o   (to_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // PHY/engine model state
  logic [15:0] phy_mem [32];
  logic [15:0] ref_mem [32];
  logic [15:0] r0_seq [$];
  logic [15:0] r0_dflt, bmsr;
  bit          withhold, busy;
  int          dly, poll_n, last_done_cyc, last_poll_cyc;
  txn_t        cur;
  txn_t        log_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    n_tests++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic check_txn(input string name, input txn_t t, input logic rw,
                           input logic [4:0] a, input logic [15:0] d);
    check(name, 64'({t.rdwr, t.rega, t.rdwr ? t.din : 16'h0}), 64'({rw, a, rw ? d : 16'h0}));
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({bus.op_ena, bus.op_rdwr, bus.op_phya, bus.op_rega, bus.op_din, host_ack,
                     host_dout, init_done, init_err, link_up, an_done, to_err}), 64'd0);
  endtask

  task automatic host_op(input logic rw, input logic [4:0] a, input logic [15:0] d,
                         output logic [15:0] dout, output int ack_c);
    bit ok;
    ok = 1'b0;
    host_req  = 1'b1;
    host_rdwr = rw;
    host_rega = a;
    host_din  = d;
    for (int n = 0; n < 1000 && !ok; n++) begin
      tick();
      ok = host_ack;
    end
    host_req = 1'b0;
    dout  = host_dout;
    ack_c = cyc;
    check("host_ack_seen", 64'(ok), 64'd1);
    tick();
    check("host_ack_one_cycle", 64'(host_ack), 64'd0);
  endtask

  task automatic wait_poll();
    int start;
    bit ok;
    start = poll_n;
    ok    = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      tick();
      ok = (poll_n != start);
    end
    check("poll_seen", 64'(ok), 64'd1);
  endtask

  task automatic wait_init();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      tick();
      ok = init_done || init_err;
    end
    check("init_finished", 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    log_q.delete();
    rst_n = 1'b1;
  endtask

  // Engine model: answers each op_ena after a random delay unless withholding.
  initial begin
    bus.op_done = 1'b0;
    bus.op_dout = 16'h0000;
    busy   = 1'b0;
    dly    = 0;
    poll_n = 0;
    last_done_cyc = 0;
    last_poll_cyc = 0;
    forever begin
      tick();
      bus.op_done = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          if (dly == 0) begin
            check("op_fields_held", 64'({bus.op_rdwr, bus.op_rega, bus.op_din}),
                  64'({cur.rdwr, cur.rega, cur.din}));
            busy = 1'b0;
            bus.op_done = 1'b1;
            if (cur.rdwr) begin
              phy_mem[cur.rega] = cur.din;
              bus.op_dout = 16'($urandom);
            end else if (cur.rega == 5'd0) begin
              if (r0_seq.size() > 0) bus.op_dout = r0_seq.pop_front();
              else                   bus.op_dout = r0_dflt;
            end else if (cur.rega == 5'd1) begin
              bus.op_dout   = bmsr;
              poll_n++;
              last_poll_cyc = cyc;
            end else begin
              bus.op_dout = phy_mem[cur.rega];
            end
            last_done_cyc = cyc;
          end else begin
            dly--;
          end
        end
        if (bus.op_ena) begin
          check("one_outstanding", 64'(busy), 64'd0);
          check("op_phya", 64'(bus.op_phya), 64'(PhyA));
          cur = '{rdwr: bus.op_rdwr, rega: bus.op_rega, din: bus.op_din, cyc: cyc,
                  gap: cyc - last_done_cyc};
          log_q.push_back(cur);
          if (!withhold) begin
            busy = 1'b1;
            dly  = $urandom_range(2, 12);
          end
        end
      end
    end
  end

  initial begin
    txn_t        init_exp [6];
    hvec_t       hv [6];
    logic [15:0] hd;
    int          ack_c, n0, target, nr0;
    bit          ok;
    logic        rw, tmo;
    logic [4:0]  a;
    logic [15:0] d;

    init_exp[0] = '{rdwr: 1'b1, rega: 5'd0, din: 16'h8000, cyc: 0, gap: 0};
    init_exp[1] = '{rdwr: 1'b0, rega: 5'd0, din: 16'h0000, cyc: 0, gap: 0};
    init_exp[2] = init_exp[1];
    init_exp[3] = init_exp[1];
    init_exp[4] = '{rdwr: 1'b1, rega: 5'd4, din: Anar, cyc: 0, gap: 0};
    init_exp[5] = '{rdwr: 1'b1, rega: 5'd0, din: 16'h1200, cyc: 0, gap: 0};

    hv[0] = '{rw: 1'b1, a: 5'd31, d: 16'hBEEF, exp: 16'h0000};
    hv[1] = '{rw: 1'b0, a: 5'd2,  d: 16'h0000, exp: 16'h0022};
    hv[2] = '{rw: 1'b0, a: 5'd9,  d: 16'h0000, exp: 16'h0300};
    hv[3] = '{rw: 1'b0, a: 5'd31, d: 16'h0000, exp: 16'hBEEF};
    hv[4] = '{rw: 1'b1, a: 5'd9,  d: 16'h5A5A, exp: 16'h0000};
    hv[5] = '{rw: 1'b0, a: 5'd9,  d: 16'h0000, exp: 16'h5A5A};

    for (int i = 0; i < 32; i++) begin
      phy_mem[i] = 16'(i * 257);
      ref_mem[i] = 16'(i * 257);
    end
    phy_mem[2] = 16'h0022;
    ref_mem[2] = 16'h0022;
    host_req  = 1'b0;
    host_rdwr = 1'b0;
    host_rega = 5'd0;
    host_din  = 16'h0000;
    withhold  = 1'b0;
    bmsr      = 16'h7829;
    r0_dflt   = 16'h1140;
    r0_seq    = '{16'h8000, 16'h8000, 16'h1140};
    rst_n     = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_outputs");

    // Bring-up with two busy reset polls
    rst_n = 1'b1;
    wait_init();
    check("init_done", 64'(init_done), 64'd1);
    check("init_err", 64'(init_err), 64'd0);
    check("init_txn_count", 64'(log_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      check_txn($sformatf("init_txn%0d", i), log_q[i], init_exp[i].rdwr, init_exp[i].rega,
                init_exp[i].din);
    ref_mem[4] = Anar;

    // Status polling
    wait_poll();
    tick();
    tick();
    check_txn("poll_txn", log_q[$], 1'b0, 5'd1, 16'h0);
    check_range("poll_gap", log_q[$].gap, PollDiv, PollDiv + 4);
    check("link_up_7829", 64'(link_up), 64'd0);
    check("an_done_7829", 64'(an_done), 64'd1);
    bmsr = 16'h782D;
    wait_poll();
    tick();
    tick();
    check_range("poll_gap2", log_q[$].gap, PollDiv, PollDiv + 4);
    check("link_up_782d", 64'(link_up), 64'd1);

    // Host request on the exact cycle the poll counter expires
    wait_poll();
    target = last_poll_cyc + PollDiv;
    while (cyc < target) tick();
    n0 = log_q.size();
    host_op(1'b1, 5'd9, 16'h0300, hd, ack_c);
    ref_mem[9] = 16'h0300;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      ok = log_q.size() >= n0 + 2;
    end
    check("collide_two_txns", 64'(ok), 64'd1);
    if (ok) begin
      check_txn("collide_host_first", log_q[n0], 1'b1, 5'd9, 16'h0300);
      check_txn("collide_poll_next", log_q[n0 + 1], 1'b0, 5'd1, 16'h0);
      check_range("collide_poll_latency", log_q[n0 + 1].cyc - ack_c, 1, 3);
    end

    // Host vector table
    for (int i = 0; i < 6; i++) begin
      host_op(hv[i].rw, hv[i].a, hv[i].d, hd, ack_c);
      check_txn($sformatf("hv%0d_txn", i), log_q[$], hv[i].rw, hv[i].a, hv[i].d);
      if (hv[i].rw) ref_mem[hv[i].a] = hv[i].d;
      else          check($sformatf("hv%0d_dout", i), 64'(hd), 64'(hv[i].exp));
    end

    // Host read timeout
    wait_poll();
    check("to_err_before", 64'(to_err), 64'd0);
    withhold = 1'b1;
    host_op(1'b0, 5'd5, 16'h0000, hd, ack_c);
    check("tmo_host_dout", 64'(hd), 64'hFFFF);
    check("tmo_to_err", 64'(to_err), 64'd1);
    check_txn("tmo_host_txn", log_q[$], 1'b0, 5'd5, 16'h0);
    check_range("tmo_host_latency", ack_c - log_q[$].cyc, Tmo, Tmo + 3);

    // Poll timeout
    check("link_before_poll_tmo", 64'(link_up), 64'd1);
    n0 = log_q.size();
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      tick();
      ok = log_q.size() > n0;
    end
    check("tmo_poll_issued", 64'(ok), 64'd1);
    check_txn("tmo_poll_txn", log_q[$], 1'b0, 5'd1, 16'h0);
    repeat (Tmo + 5) tick();
    check("tmo_poll_link", 64'(link_up), 64'd0);
    check("tmo_poll_an", 64'(an_done), 64'd1);
    check("tmo_poll_single", 64'(log_q.size()), 64'(n0 + 1));
    withhold = 1'b0;

    // Randomized host traffic against the register-file reference
    for (int i = 0; i < 30; i++) begin
      rw  = 1'($urandom);
      a   = 5'($urandom_range(5, 31));
      d   = 16'($urandom);
      tmo = ($urandom_range(0, 7) == 0);
      bmsr = 16'($urandom);
      withhold = tmo;
      host_op(rw, a, d, hd, ack_c);
      withhold = 1'b0;
      check_txn("rnd_txn", log_q[$], rw, a, d);
      if (tmo)     check("rnd_tmo_dout", 64'(hd), 64'hFFFF);
      else if (rw) ref_mem[a] = d;
      else         check("rnd_rd_dout", 64'(hd), 64'(ref_mem[a]));
    end
    bmsr = 16'($urandom);
    wait_poll();
    wait_poll();
    tick();
    tick();
    check("rnd_link_up", 64'(link_up), 64'(bmsr[2]));
    check("rnd_an_done", 64'(an_done), 64'(bmsr[5]));

    // Soft reset never clears
    r0_seq.delete();
    r0_dflt = 16'h8000;
    do_reset();
    wait_init();
    nr0 = 0;
    foreach (log_q[i]) if (!log_q[i].rdwr && log_q[i].rega == 5'd0) nr0++;
    check("rstpoll_reads", 64'(nr0), 64'(RstPolls));
    check("rstpoll_err", 64'(init_err), 64'd1);
    check("rstpoll_done", 64'(init_done), 64'd0);
    wait_poll();
    check_txn("rstpoll_then_poll", log_q[$], 1'b0, 5'd1, 16'h0);

    // Asynchronous reset while the ANAR write is outstanding
    r0_dflt = 16'h1140;
    do_reset();
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      tick();
      ok = log_q.size() > 0 && log_q[$].rdwr && log_q[$].rega == 5'd4;
    end
    check("anar_issued", 64'(ok), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    tick();
    tick();
    log_q.delete();
    rst_n = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      ok = log_q.size() > 0;
    end
    check("restart_issued", 64'(ok), 64'd1);
    if (ok) check_txn("restart_w0", log_q[0], 1'b1, 5'd0, 16'h8000);
    wait_init();
    check("restart_init_done", 64'(init_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
